// File: rtl/program_loader_pkg.sv
// ---------------------------------------------------------------------------
// program_loader_pkg
//   Shared definitions for the program loader: default geometry of a program
//   image and the loader state encoding.
//
//   Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN
//     When defined, the loader expects one trailing checksum word after the
//     image and verifies it against the XOR of all image words.
// ---------------------------------------------------------------------------
package program_loader_pkg;

    localparam int WORD_W_DEF = 6;   // instruction word width
    localparam int ADDR_W_DEF = 5;   // program memory address width
    localparam int DEPTH_DEF  = 32;  // words per image (2**ADDR_W)

    // ST_CHECK is only reachable when PROGRAM_LOADER_CHECKSUM_EN is defined.
    // ST_ERROR is only reachable through a failed checksum.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

endpackage

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//   Streams a program image (DEPTH words) from a valid/ready source into an
//   external writable program memory while holding the CPU in reset, then
//   releases the CPU once the final word has been written.
//
//   Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN
//     Adds a CHECK state that accepts one extra word after the image and
//     compares it with the XOR of all image words; mismatch -> ERROR.
//     Without the macro the accumulator does not exist and error is 0.
//
//   Handshake: a word transfers on a rising clk edge where in_valid and
//   in_ready are both 1. in_ready depends only on the loader state, never on
//   in_valid; the source may hold in_valid low for any number of cycles.
//
//   Ports
//     clk        in   system clock, rising edge
//     nReset     in   asynchronous active-low reset
//     start      in   one-cycle load request (ignored while busy)
//     in_valid   in   source word available
//     in_data    in   source word [WORD_W]
//     in_ready   out  loader accepts a word this cycle
//     mem_we     out  program memory write strobe (cycle after a transfer)
//     mem_addr   out  program memory write address [ADDR_W]
//     mem_wdata  out  program memory write data [WORD_W]
//     cpu_nReset out  active-low reset for PC/ID/datapath
//     busy       out  load (or checksum) in progress
//     done       out  image loaded, CPU released
//     error      out  checksum mismatch (constant 0 without the macro)
//     dbg_state  out  current FSM state encoding (state_t)
// ---------------------------------------------------------------------------
module program_loader
    import program_loader_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_nReset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        dbg_state
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              xfer;
    logic              last_word;
    logic              load_begin;

    assign xfer       = in_valid && (state_q == ST_LOAD);
    assign last_word  = (cnt_q == ADDR_W'(DEPTH - 1));
    assign load_begin = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] csum_q;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            csum_q <= '0;
        end else if (load_begin) begin
            csum_q <= '0;
        end else if (xfer) begin
            csum_q <= csum_q ^ in_data;
        end
    end
`endif

    // State and word counter
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) begin
                    // Explicit wrap keeps the counter within DEPTH-1 even if
                    // DEPTH is ever set below 2**ADDR_W.
                    cnt_d = last_word ? '0 : cnt_q + 1'b1;
                    if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    state_d = (in_data == csum_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write port: one registered strobe per transfer. Reset clears a pending
    // strobe so an interrupted load never writes its in-flight word.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= xfer;
            if (xfer) begin
                mem_addr  <= cnt_q;
                mem_wdata <= in_data;
            end
        end
    end

    // DONE is entered together with the final write strobe; masking with
    // mem_we delays the CPU release to the cycle after that last write.
    assign cpu_nReset = (state_q == ST_DONE) && !mem_we;
    assign done       = (state_q == ST_DONE) && !mem_we;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign error = (state_q == ST_ERROR);
`else
    assign error = 1'b0;
`endif

    assign dbg_state = state_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int WORD_W = 6;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              nReset;
  logic              start;
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              cpu_nReset;
  logic              busy;
  logic              done;
  logic              error;
  logic [2:0]        dbg_state;

  int checks    = 0;
  int failures  = 0;
  int wr_cnt    = 0;
  int exp_total = 0;

  logic [ADDR_W+WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0]        img[DEPTH];

  program_loader #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .nReset     (nReset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_nReset (cpu_nReset),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write strobe must match the oldest transferred word
  always @(negedge clk) begin
    logic [ADDR_W+WORD_W-1:0] e;
    if (mem_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e[ADDR_W+WORD_W-1:WORD_W]));
        check("wr_data", 32'(mem_wdata), 32'(e[WORD_W-1:0]));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic fill_image(input int mode);
    for (int k = 0; k < DEPTH; k++) begin
      case (mode)
        0:       img[k] = WORD_W'(k);
        1:       img[k] = WORD_W'($urandom);
        default: img[k] = 6'h15;
      endcase
    end
  endtask

  function automatic logic [WORD_W-1:0] img_xor();
    logic [WORD_W-1:0] x = '0;
    for (int k = 0; k < DEPTH; k++) x = x ^ img[k];
    return x;
  endfunction

  // Presents words 0..n_words-1; a loader in LOAD takes every presented word.
  task automatic stream(input int n_words, input int gap_after, input int gap_len,
                        input int start_at, input bit rnd_stall);
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < n_words; k++) begin
      if (rnd_stall && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = WORD_W'($urandom);
        repeat ($urandom_range(1, 2)) step();
      end
      a = ADDR_W'(k);
      in_valid = 1'b1;
      in_data  = img[k];
      exp_q.push_back({a, img[k]});
      exp_total++;
      if (k == start_at) start = 1'b1;
      if (k == 0 || k == start_at || k == DEPTH - 1) check("in_ready_load", 32'(in_ready), 32'd1);
      step();
      start = 1'b0;
      if (k == gap_after) begin
        in_valid = 1'b0;
        repeat (gap_len) step();
      end
    end
    in_valid = 1'b0;
  endtask

  // Called the cycle after the final image word transferred.
  task automatic finish_image(input logic [WORD_W-1:0] csum, input bit ok);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    check("check_in_ready", 32'(in_ready), 32'd1);
    check("check_busy", 32'(busy), 32'd1);
    in_valid = 1'b1;
    in_data  = csum;
    step();
    in_valid = 1'b0;
    check("end_done", 32'(done), 32'(ok));
    check("end_error", 32'(error), 32'(!ok));
    check("end_cpu_nrst", 32'(cpu_nReset), 32'(ok));
    check("end_busy", 32'(busy), 32'd0);
`else
    check("last_we", 32'(mem_we), 32'd1);
    check("cpu_held_on_last_we", 32'(cpu_nReset), 32'd0);
    check("done_low_on_last_we", 32'(done), 32'd0);
    step();
    check("end_cpu_nrst", 32'(cpu_nReset), 32'd1);
    check("end_done", 32'(done), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_in_ready", 32'(in_ready), 32'd0);
    check("end_error", 32'(error), 32'd0);
    check("end_no_we", 32'(mem_we), 32'd0);
    if (csum == '1 && !ok) check("unused_args", 32'd0, 32'd0);
`endif
  endtask

  initial begin
    int w0;
    nReset   = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu_nrst", 32'(cpu_nReset), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    repeat (2) step();
    nReset = 1'b1;
    step();

    // idle: offered words are not taken
    in_valid = 1'b1;
    in_data  = 6'h2a;
    check("idle_in_ready", 32'(in_ready), 32'd0);
    repeat (3) step();
    in_valid = 1'b0;
    check("idle_cpu_nrst", 32'(cpu_nReset), 32'd0);

    // ramp image, back-to-back
    fill_image(0);
    w0 = wr_cnt;
    kick();
    check("load_busy", 32'(busy), 32'd1);
    check("load_cpu_nrst", 32'(cpu_nReset), 32'd0);
    stream(DEPTH, -1, 0, -1, 1'b0);
    finish_image(img_xor(), 1'b1);
    check("ramp_write_count", 32'(wr_cnt - w0), 32'(DEPTH));

    // stall of 3 cycles after word 10
    w0 = wr_cnt;
    kick();
    stream(DEPTH, 10, 3, -1, 1'b0);
    finish_image(img_xor(), 1'b1);
    check("gap_write_count", 32'(wr_cnt - w0), 32'(DEPTH));

    // random data, random stalls, start pulsed during load at word 5
    fill_image(1);
    w0 = wr_cnt;
    kick();
    stream(DEPTH, -1, 0, 5, 1'b1);
    finish_image(img_xor(), 1'b1);
    check("rnd_write_count", 32'(wr_cnt - w0), 32'(DEPTH));

    // start from DONE reloads from address 0
    fill_image(0);
    kick();
    check("restart_cpu_nrst", 32'(cpu_nReset), 32'd0);
    check("restart_done", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    stream(DEPTH, -1, 0, -1, 1'b0);
    finish_image(img_xor(), 1'b1);

    // reset mid-load while word 20 is offered
    kick();
    stream(20, -1, 0, -1, 1'b0);
    step();
    in_valid = 1'b1;
    in_data  = img[20];
    #2;
    nReset = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("mid_rst_cpu_nrst", 32'(cpu_nReset), 32'd0);
    step();
    check("mid_rst_hold_we", 32'(mem_we), 32'd0);
    nReset = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("post_rst_in_ready", 32'(in_ready), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_done", 32'(done), 32'd0);
    check("post_rst_we", 32'(mem_we), 32'd0);
    check("post_rst_queue", 32'(exp_q.size()), 32'd0);

    // fresh load after reset
    fill_image(1);
    kick();
    stream(DEPTH, -1, 0, -1, 1'b1);
    finish_image(img_xor(), 1'b1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    fill_image(2);
    kick();
    stream(DEPTH, -1, 0, -1, 1'b0);
    finish_image(6'h00, 1'b1);
    kick();
    stream(DEPTH, -1, 0, -1, 1'b0);
    finish_image(6'h01, 1'b0);
    kick();
    check("err_restart_error", 32'(error), 32'd0);
    check("err_restart_cpu_nrst", 32'(cpu_nReset), 32'd0);
    fill_image(1);
    stream(DEPTH, -1, 0, -1, 1'b1);
    finish_image(img_xor() ^ 6'h20, 1'b0);
`endif

    repeat (3) step();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_write_total", 32'(wr_cnt), 32'(exp_total));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
